// File: rtl/hilo_unit_if.sv
// HI/LO unit bus: issue, MT writes, MF reads and status.
// master = pipeline side, slave = hilo_unit side.
`ifndef ALUOP_MULT
`define ALUOP_MULT  5'b11000
`endif
`ifndef ALUOP_MULTU
`define ALUOP_MULTU 5'b11001
`endif
`ifndef ALUOP_DIV
`define ALUOP_DIV   5'b11010
`endif
`ifndef ALUOP_DIVU
`define ALUOP_DIVU  5'b11011
`endif

interface hilo_unit_if;
    logic        op_valid_i;
    logic [4:0]  ALU_control_i;
    logic [63:0] ALU_result_i;
    logic        mthi_i;
    logic        mtlo_i;
    logic [31:0] wdata_i;
    logic        mf_req_i;
    logic        mf_sel_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] mf_data_o;
    logic        busy_o;
    logic        stall_o;

    modport master (
        output op_valid_i, ALU_control_i, ALU_result_i,
        output mthi_i, mtlo_i, wdata_i, mf_req_i, mf_sel_i,
        input  hi_o, lo_o, mf_data_o, busy_o, stall_o
    );

    modport slave (
        input  op_valid_i, ALU_control_i, ALU_result_i,
        input  mthi_i, mtlo_i, wdata_i, mf_req_i, mf_sel_i,
        output hi_o, lo_o, mf_data_o, busy_o, stall_o
    );
endinterface

// File: rtl/hilo_unit.sv
// Architectural HI/LO with latency-modelled mul/div commit.
// HILO_BYPASS_EN: forward the pending result on the commit cycle.
module hilo_unit #(
    parameter int MUL_LATENCY = 5,
    parameter int DIV_LATENCY = 33
) (
    input logic        clk_i,
    input logic        rst_i,
    hilo_unit_if.slave bus
);

    if (MUL_LATENCY < 1 || MUL_LATENCY > 64) begin : g_bad_mul
        $error("hilo_unit: MUL_LATENCY out of range 1..64");
    end
    if (DIV_LATENCY < 1 || DIV_LATENCY > 64) begin : g_bad_div
        $error("hilo_unit: DIV_LATENCY out of range 1..64");
    end

    localparam logic [5:0] MUL_CNT = 6'(MUL_LATENCY - 1);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_cnt, w_cnt_nxt;
    logic [63:0] r_pend, w_pend_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;

    logic w_is_mul, w_is_div, w_issue, w_commit;

    assign w_is_mul = (bus.ALU_control_i == `ALUOP_MULT)
                   || (bus.ALU_control_i == `ALUOP_MULTU);
    assign w_is_div = (bus.ALU_control_i == `ALUOP_DIV)
                   || (bus.ALU_control_i == `ALUOP_DIVU);
    assign w_issue  = bus.op_valid_i && (w_is_mul || w_is_div);
    assign w_commit = (r_state == BUSY) && (r_cnt == 6'd0);

    // State, counter, pending result and HI/LO registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= 6'd0;
            r_pend  <= 64'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Next state: issue beats MT, MT aborts, else count down and commit
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        if (w_issue) begin
            w_pend_nxt  = bus.ALU_result_i;
            w_cnt_nxt   = w_is_div ? DIV_CNT : MUL_CNT;
            w_state_nxt = BUSY;
        end else if (bus.mthi_i || bus.mtlo_i) begin
            if (bus.mthi_i) w_hi_nxt = bus.wdata_i;
            if (bus.mtlo_i) w_lo_nxt = bus.wdata_i;
            w_cnt_nxt   = 6'd0;
            w_state_nxt = IDLE;
        end else if (r_state == BUSY) begin
            if (r_cnt == 6'd0) begin
                w_hi_nxt    = r_pend[63:32];
                w_lo_nxt    = r_pend[31:0];
                w_state_nxt = IDLE;
            end else begin
                w_cnt_nxt = r_cnt - 6'd1;
            end
        end
    end

    assign bus.hi_o   = r_hi;
    assign bus.lo_o   = r_lo;
    assign bus.busy_o = (r_state == BUSY);

`ifdef HILO_BYPASS_EN
    assign bus.stall_o   = bus.mf_req_i && bus.busy_o && !w_commit;
    assign bus.mf_data_o = w_commit
                         ? (bus.mf_sel_i ? r_pend[63:32] : r_pend[31:0])
                         : (bus.mf_sel_i ? r_hi : r_lo);
`else
    logic w_unused;
    assign w_unused      = w_commit;
    assign bus.stall_o   = bus.mf_req_i && bus.busy_o;
    assign bus.mf_data_o = bus.mf_sel_i ? r_hi : r_lo;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit.
// Expected stall length follows HILO_BYPASS_EN.
`timescale 1ns/1ps
module tb_hilo_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hilo_unit_if bus();

    hilo_unit #(.MUL_LATENCY(5), .DIV_LATENCY(33)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;

`ifdef HILO_BYPASS_EN
    localparam int EXP_STALL = 31;
`else
    localparam int EXP_STALL = 32;
`endif

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [63:0] res);
        bus.op_valid_i    = 1'b1;
        bus.ALU_control_i = op;
        bus.ALU_result_i  = res;
        step(1);
        bus.op_valid_i    = 1'b0;
        bus.ALU_control_i = 5'd0;
        bus.ALU_result_i  = 64'd0;
    endtask

    int nst;

    initial begin
        bus.op_valid_i    = 1'b0;
        bus.ALU_control_i = 5'd0;
        bus.ALU_result_i  = 64'd0;
        bus.mthi_i        = 1'b0;
        bus.mtlo_i        = 1'b0;
        bus.wdata_i       = 32'd0;
        bus.mf_req_i      = 1'b0;
        bus.mf_sel_i      = 1'b0;

        // reset for 2 cycles
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        #1;
        chk("rst_hi", bus.hi_o, 0);
        chk("rst_lo", bus.lo_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_stall", bus.stall_o, 0);

        // non mul/div opcode is ignored
        issue(5'd0, 64'h1234_5678_9ABC_DEF0);
        chk("ign_busy", bus.busy_o, 0);

        // MULT, latency 5
        issue(`ALUOP_MULT, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("mul_nostall", bus.stall_o, 0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("mul_busy%0d", i), bus.busy_o, 1);
            chk($sformatf("mul_lo_old%0d", i), bus.lo_o, 0);
            step(1);
        end
        chk("mul_busy_end", bus.busy_o, 0);
        chk("mul_hi", bus.hi_o, 32'hFFFF_FFFF);
        chk("mul_lo", bus.lo_o, 32'hFFFF_FFFA);

        // idle MF read does not stall
        bus.mf_req_i = 1'b1;
        bus.mf_sel_i = 1'b1;
        #1;
        chk("idle_stall", bus.stall_o, 0);
        chk("idle_mfhi", bus.mf_data_o, 32'hFFFF_FFFF);
        bus.mf_req_i = 1'b0;

        // DIVU 7/2, MFLO one cycle into the busy window
        issue(`ALUOP_DIVU, {32'd1, 32'd3});
        step(1);
        bus.mf_req_i = 1'b1;
        bus.mf_sel_i = 1'b0;
        #1;
        nst = 0;
        while (bus.stall_o && nst < 100) begin
            nst++;
            step(1);
        end
        chk("div_stall_len", nst, EXP_STALL);
        chk("div_mflo", bus.mf_data_o, 3);
        bus.mf_req_i = 1'b0;
        step(1);
        chk("div_hi", bus.hi_o, 1);
        chk("div_lo", bus.lo_o, 3);
        chk("div_busy", bus.busy_o, 0);

        // MULT overwritten by DIV issued 2 cycles later
        issue(`ALUOP_MULT, 64'hAAAA_AAAA_5555_5555);
        step(1);
        issue(`ALUOP_DIV, 64'h0000_0004_0000_0009);
        for (int i = 0; i < 33; i++) begin
            chk($sformatf("ovr_lo%0d", i), bus.lo_o, 3);
            step(1);
        end
        chk("ovr_hi", bus.hi_o, 32'h4);
        chk("ovr_lo", bus.lo_o, 32'h9);
        chk("ovr_busy", bus.busy_o, 0);
        step(10);
        chk("ovr_nomul", bus.lo_o, 32'h9);

        // MTHI aborts a pending MULTU
        issue(`ALUOP_MULTU, 64'h1111_1111_2222_2222);
        step(1);
        bus.mthi_i  = 1'b1;
        bus.wdata_i = 32'hDEAD_BEEF;
        step(1);
        bus.mthi_i  = 1'b0;
        chk("mt_busy", bus.busy_o, 0);
        chk("mt_hi", bus.hi_o, 32'hDEAD_BEEF);
        chk("mt_lo", bus.lo_o, 32'h9);
        step(10);
        chk("mt_nocommit", bus.lo_o, 32'h9);

        // MTLO with issue: issue wins
        bus.mtlo_i  = 1'b1;
        bus.wdata_i = 32'h1234_5678;
        issue(`ALUOP_MULT, 64'h0000_0000_0000_0006);
        bus.mtlo_i  = 1'b0;
        chk("mtiss_busy", bus.busy_o, 1);
        chk("mtiss_lo", bus.lo_o, 32'h9);
        step(5);
        chk("mtiss_hi_c", bus.hi_o, 0);
        chk("mtiss_lo_c", bus.lo_o, 6);

        // MTHI+MTLO together
        bus.mthi_i  = 1'b1;
        bus.mtlo_i  = 1'b1;
        bus.wdata_i = 32'hCAFE_F00D;
        step(1);
        bus.mthi_i  = 1'b0;
        bus.mtlo_i  = 1'b0;
        chk("mtboth_hi", bus.hi_o, 32'hCAFE_F00D);
        chk("mtboth_lo", bus.lo_o, 32'hCAFE_F00D);

        // reset on cycle 3 of a pending DIV
        issue(`ALUOP_DIV, 64'h0000_0007_0000_0008);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rdiv_hi", bus.hi_o, 0);
        chk("rdiv_lo", bus.lo_o, 0);
        chk("rdiv_busy", bus.busy_o, 0);
        step(40);
        chk("rdiv_nocommit", bus.lo_o, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
